// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;

  // Pointer width: log2(DEPTH), never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: one extra bit so that count can reach DEPTH.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port; the array itself has no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AW     = ptr_w(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A same-edge write to the read address returns the old word, which is what full read+write needs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO: pointers, occupancy count, level flags and sticky error flags.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic          mem_we, mem_re;

  // A full FIFO still takes a write when a read frees the head slot on the same edge.
  assign rd_acc = read_en && !empty;
  assign wr_acc = write_en && (!full || read_en);
  assign mem_we = wr_acc && !clear;
  assign mem_re = rd_acc && !clear;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (rd_acc) begin
        rptr_d = rptr_q + PW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (write_en && full && !read_en) begin
        ovf_d = 1'b1;
      end
      if (read_en && empty) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (data_in),
    .re_i    (mem_re),
    .raddr_i (rptr_q),
    .rdata_o (out)
  );

  assign count        = count_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed vector table, corner sequences and a queue-based model.
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset, clear, write_en, read_en;
  logic [DW-1:0] data_in, out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;

  int checks = 0;
  int errors = 0;

  param_sync_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .write_en     (write_en),
    .read_en      (read_en),
    .data_in      (data_in),
    .out          (out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we, re, clr;
    logic [7:0]  din;
    logic [7:0]  e_out;
    int          e_cnt;
    bit          e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: occupancy is just the queue size.
  logic [7:0] mq[$];
  logic [7:0] m_out;
  bit         m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] e_out, input int e_cnt,
                           input bit e_ovf, input bit e_unf);
    chk({tag, " out"},          32'(out),          32'(e_out));
    chk({tag, " count"},        32'(count),        32'(e_cnt));
    chk({tag, " full"},         32'(full),         32'(e_cnt == DEPTH));
    chk({tag, " empty"},        32'(empty),        32'(e_cnt == 0));
    chk({tag, " almost_full"},  32'(almost_full),  32'(e_cnt >= AF));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(e_cnt <= AE));
    chk({tag, " overflow"},     32'(overflow),     32'(e_ovf));
    chk({tag, " underflow"},    32'(underflow),    32'(e_unf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_apply(input bit we, input bit re, input bit clr, input logic [7:0] din);
    bit is_full, is_empty;
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      is_full  = (mq.size() == DEPTH);
      is_empty = (mq.size() == 0);
      if (re && is_empty) m_unf = 1'b1;
      if (we && is_full && !re) m_ovf = 1'b1;
      if (re && !is_empty) m_out = mq.pop_front();
      if (we && (!is_full || re)) mq.push_back(din);
    end
  endtask

  task automatic step(input bit we, input bit re, input bit clr, input logic [7:0] din,
                      input string tag);
    write_en = we;
    read_en  = re;
    clear    = clr;
    data_in  = din;
    @(posedge clk);
    model_apply(we, re, clr, din);
    #1;
    chk_state(tag, m_out, mq.size(), m_ovf, m_unf);
    write_en = 1'b0;
    read_en  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic add_vec(input bit we, input bit re, input bit clr, input logic [7:0] din,
                         input logic [7:0] e_out, input int e_cnt, input bit e_ovf, input bit e_unf);
    vec_t v;
    v.we = we; v.re = re; v.clr = clr; v.din = din;
    v.e_out = e_out; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endtask

  initial begin
    reset    = 1'b0;
    clear    = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    #1;
    chk_state("reset", 8'h00, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed table: fill, overflow, drain, empty read+write, read back, clear.
    for (int i = 0; i < 16; i++) add_vec(1, 0, 0, 8'(i + 1), 8'h00, i + 1, 0, 0);
    add_vec(1, 0, 0, 8'h11, 8'h00, 16, 1, 0);
    for (int j = 0; j < 16; j++) add_vec(0, 1, 0, 8'h00, 8'(j + 1), 15 - j, 1, 0);
    add_vec(1, 1, 0, 8'h55, 8'h10, 1, 1, 1);
    add_vec(0, 1, 0, 8'h00, 8'h55, 0, 1, 1);
    add_vec(1, 1, 1, 8'h77, 8'h55, 0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      write_en = vecs[k].we;
      read_en  = vecs[k].re;
      clear    = vecs[k].clr;
      data_in  = vecs[k].din;
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", k), vecs[k].e_out, vecs[k].e_cnt, vecs[k].e_ovf, vecs[k].e_unf);
    end
    write_en = 1'b0;
    read_en  = 1'b0;
    clear    = 1'b0;

    // Reset asserted between edges mid-traffic must act without a clock.
    model_reset();
    m_out = 8'h55;
    for (int k = 0; k < 3; k++) step(1, 0, 0, 8'(8'hC0 + k), "pre_rst");
    write_en = 1'b1;
    data_in  = 8'hEE;
    #2;
    reset = 1'b0;
    #1;
    chk_state("async_rst", 8'h00, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_state("rst_hold", 8'h00, 0, 1'b0, 1'b0);
    write_en = 1'b0;
    reset    = 1'b1;
    model_reset();

    // Full FIFO: simultaneous read and write of 0xAA.
    for (int k = 0; k < 16; k++) step(1, 0, 0, 8'(k + 1), "fill2");
    step(1, 1, 0, 8'hAA, "full_rw");
    chk("full_rw out01", 32'(out), 32'h01);
    chk("full_rw cnt16", 32'(count), 32'd16);
    chk("full_rw no_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 16; k++) step(0, 1, 0, 8'h00, "drain2");
    chk("last_is_AA", 32'(out), 32'hAA);

    // Randomised traffic with phase-dependent bias to reach both full and empty.
    for (int k = 0; k < 600; k++) begin
      bit we, re, clr;
      if (k < 200) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else if (k < 400) begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 3) != 0);
      end else begin
        we = $urandom_range(0, 1) != 0;
        re = $urandom_range(0, 1) != 0;
      end
      clr = ($urandom_range(0, 79) == 0);
      step(we, re, clr, 8'($urandom), "rand");
    end

    // Interleaved traffic across pointer wrap, then clear with requests present.
    step(0, 0, 1, 8'h00, "pre_wrap_clr");
    for (int k = 0; k < 5; k++) step(1, 0, 0, 8'(8'h30 + k), "wrap_pre");
    for (int k = 0; k < 40; k++) step((k % 3) != 2, (k % 3) != 1, 0, 8'(8'h40 + k), "wrap");
    step(1, 1, 1, 8'hFF, "final_clr");
    chk("final_clr cnt0", 32'(count), 32'd0);
    chk("final_clr empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
